// File: rtl/ascon_arb_pkg.sv
// Shared types and widths for the Ascon job arbiter.
// The arbiter, its round-robin picker and the Ascon core interface use these.
package ascon_arb_pkg;

  localparam int KEY_W   = 128;
  localparam int NONCE_W = 128;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RUN,
    DONE,
    ABORT
  } arb_state_e;

endpackage

// File: rtl/ascon_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester with req set, searching upward from ptr and wrapping.
module ascon_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any
);

  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

  logic [PW:0] sum;

  // One extra bit holds ptr+offset before the modulo fold, so odd NUM_REQ wraps correctly
  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= NR) sum = sum - NR;
      if (!any && req[sum[PW-1:0]]) begin
        winner[sum[PW-1:0]] = 1'b1;
        any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascon_job_arbiter.sv
// Shares one Ascon core between NUM_REQ requesters, one whole job at a time,
// with round-robin fairness, a GRANT/RUN watchdog and start-protocol checking.
module ascon_job_arbiter
  import ascon_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*KEY_W-1:0]   key_i,
  input  logic [NUM_REQ-1:0]         key_valid_i,
  input  logic [NUM_REQ*NONCE_W-1:0] nonce_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_in_i,
  input  logic [NUM_REQ-1:0]         data_in_valid_i,
  input  logic [NUM_REQ-1:0]         start_enc_i,
  input  logic [NUM_REQ-1:0]         start_dec_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [DATA_W-1:0]          data_out_o,
  output logic [NUM_REQ-1:0]         data_out_valid_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [NUM_REQ-1:0]         auth_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [KEY_W-1:0]           core_key_o,
  output logic                       core_key_valid_o,
  output logic [NONCE_W-1:0]         core_nonce_o,
  output logic [DATA_W-1:0]          core_data_in_o,
  output logic                       core_data_in_valid_o,
  output logic                       core_start_enc_o,
  output logic                       core_start_dec_o,
  output logic                       core_clr_o,
  input  logic [DATA_W-1:0]          core_data_out_i,
  input  logic                       core_data_out_valid_i,
  input  logic                       core_busy_i,
  input  logic                       core_done_i,
  input  logic                       core_auth_i
);

  localparam int             PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(NUM_REQ - 1);
  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [NUM_REQ-1:0]  done_q, done_d, auth_q, auth_d, err_q, err_d;
  logic                clr_q, clr_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;
  logic [PW-1:0]       pick_idx;
  logic                sel_req, sel_enc, sel_dec;
  logic                in_job, wd_expired;

  ascon_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .winner (pick_gnt),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
  end

  assign in_job     = (state_q == GRANT) || (state_q == RUN);
  assign wd_expired = WD_EN && (wd_q == WD_LIMIT);

  // Route the granted requester's fields to the core; qualifiers only live during GRANT/RUN
  always_comb begin
    core_key_o           = '0;
    core_nonce_o         = '0;
    core_data_in_o       = '0;
    core_key_valid_o     = 1'b0;
    core_data_in_valid_o = 1'b0;
    sel_req              = 1'b0;
    sel_enc              = 1'b0;
    sel_dec              = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        core_key_o           = key_i[i*KEY_W +: KEY_W];
        core_nonce_o         = nonce_i[i*NONCE_W +: NONCE_W];
        core_data_in_o       = data_in_i[i*DATA_W +: DATA_W];
        core_key_valid_o     = key_valid_i[i] & in_job;
        core_data_in_valid_o = data_in_valid_i[i] & in_job;
        sel_req              = req_i[i];
        sel_enc              = start_enc_i[i];
        sel_dec              = start_dec_i[i];
      end
    end
  end

  // Next-state logic; done beats a simultaneous watchdog expiry in RUN
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    ptr_d            = ptr_q;
    done_d           = '0;
    auth_d           = '0;
    err_d            = '0;
    clr_d            = 1'b0;
    core_start_enc_o = 1'b0;
    core_start_dec_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !core_busy_i) begin
          gnt_d   = pick_gnt;
          state_d = GRANT;
          ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
        end
      end
      GRANT: begin
        if (sel_enc && sel_dec) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (sel_enc || sel_dec) begin
          core_start_enc_o = sel_enc;
          core_start_dec_o = sel_dec;
          state_d          = RUN;
        end else if (!sel_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (wd_expired) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (core_done_i) begin
          done_d  = gnt_q;
          auth_d  = core_auth_i ? gnt_q : '0;
          state_d = DONE;
        end else if (wd_expired) begin
          err_d   = gnt_q;
          clr_d   = 1'b1;
          gnt_d   = '0;
          state_d = ABORT;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q)
      wd_d = '0;
    else if (in_job && (wd_q != '1))
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      done_q  <= '0;
      auth_q  <= '0;
      err_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      auth_q  <= auth_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign done_o           = done_q;
  assign auth_o           = auth_q;
  assign err_o            = err_q;
  assign core_clr_o       = clr_q;
  assign data_out_o       = core_data_out_i;
  assign data_out_valid_o = (state_q == RUN) ? (gnt_q & {NUM_REQ{core_data_out_valid_i}}) : '0;

endmodule

// File: tb/tb_ascon_job_arbiter.sv
// Randomized self-checking bench for ascon_job_arbiter with a job-level reference
// model: round-robin winner arithmetic plus the cycle budget of each job outcome.
module tb_ascon_job_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  localparam int A_ENC      = 0;
  localparam int A_DEC      = 1;
  localparam int A_BOTH     = 2;
  localparam int A_DROP     = 3;
  localparam int A_TO_GRANT = 4;
  localparam int A_TO_RUN   = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i, key_valid_i, data_in_valid_i, start_enc_i, start_dec_i;
  logic [N*128-1:0] key_i, nonce_i;
  logic [N*32-1:0]  data_in_i;
  logic [N-1:0]     gnt_o, data_out_valid_o, done_o, auth_o, err_o;
  logic [31:0]      data_out_o;
  logic [127:0]     core_key_o, core_nonce_o;
  logic [31:0]      core_data_in_o;
  logic             core_key_valid_o, core_data_in_valid_o;
  logic             core_start_enc_o, core_start_dec_o, core_clr_o;
  logic [31:0]      core_data_out_i;
  logic             core_data_out_valid_i, core_busy_i, core_done_i, core_auth_i;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  ascon_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .req_i                 (req_i),
    .key_i                 (key_i),
    .key_valid_i           (key_valid_i),
    .nonce_i               (nonce_i),
    .data_in_i             (data_in_i),
    .data_in_valid_i       (data_in_valid_i),
    .start_enc_i           (start_enc_i),
    .start_dec_i           (start_dec_i),
    .gnt_o                 (gnt_o),
    .data_out_o            (data_out_o),
    .data_out_valid_o      (data_out_valid_o),
    .done_o                (done_o),
    .auth_o                (auth_o),
    .err_o                 (err_o),
    .core_key_o            (core_key_o),
    .core_key_valid_o      (core_key_valid_o),
    .core_nonce_o          (core_nonce_o),
    .core_data_in_o        (core_data_in_o),
    .core_data_in_valid_o  (core_data_in_valid_o),
    .core_start_enc_o      (core_start_enc_o),
    .core_start_dec_o      (core_start_dec_o),
    .core_clr_o            (core_clr_o),
    .core_data_out_i       (core_data_out_i),
    .core_data_out_valid_i (core_data_out_valid_i),
    .core_busy_i           (core_busy_i),
    .core_done_i           (core_done_i),
    .core_auth_i           (core_auth_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      key_i[i*128 +: 128]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      nonce_i[i*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
      data_in_i[i*32 +: 32] = $urandom();
    end
    key_valid_i     = N'($urandom());
    data_in_valid_i = N'($urandom());
  endtask

  function automatic int rrWinner(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    return N'(1) << w;
  endfunction

  task automatic checkMux(input int w, input bit active);
    checkOutput("core_key", core_key_o, key_i[w*128 +: 128]);
    checkOutput("core_nonce", core_nonce_o, nonce_i[w*128 +: 128]);
    checkOutput("core_din", core_data_in_o, data_in_i[w*32 +: 32]);
    checkOutput("core_key_valid", core_key_valid_o, active ? key_valid_i[w] : 1'b0);
    checkOutput("core_din_valid", core_data_in_valid_o, active ? data_in_valid_i[w] : 1'b0);
  endtask

  // One job from an IDLE cycle; returns in the next IDLE cycle with core_busy_i low
  task automatic runJob(input logic [N-1:0] reqs, input int action, input int lat,
                        input bit auth_v, input bit drop_in_run);
    int w;
    logic [N-1:0] oh;
    int hold;
    req_i = reqs; start_enc_i = '0; start_dec_i = '0;
    core_done_i = 1'b0; core_busy_i = 1'b0; core_data_out_valid_i = 1'b0;
    applyStimulus();
    #2;
    checkOutput("idle_gnt", gnt_o, '0);
    w = rrWinner(reqs, model_ptr);
    model_ptr = (w + 1) % N;
    oh = onehot(w);

    tick();
    applyStimulus();
    case (action)
      A_ENC:    begin start_enc_i = oh; start_dec_i = N'($urandom()) & ~oh; end
      A_DEC:    begin start_dec_i = oh; start_enc_i = N'($urandom()) & ~oh; end
      A_BOTH:   begin start_enc_i = oh; start_dec_i = oh; end
      A_DROP:   req_i[w] = 1'b0;
      default:  ;
    endcase
    #2;
    checkOutput("grant", gnt_o, oh);
    checkMux(w, 1'b1);
    checkOutput("core_start_enc", core_start_enc_o, action == A_ENC);
    checkOutput("core_start_dec", core_start_dec_o, action == A_DEC);

    if (action == A_ENC || action == A_DEC) begin
      for (int c = 1; c <= TO && c <= lat; c++) begin
        tick();
        applyStimulus();
        start_enc_i = N'($urandom());
        start_dec_i = N'($urandom());
        core_busy_i = 1'b1;
        core_data_out_i = $urandom();
        core_data_out_valid_i = $urandom_range(0, 1) == 1;
        core_done_i = (c == lat);
        core_auth_i = (c == lat) ? auth_v : ($urandom_range(0, 1) == 1);
        if (drop_in_run) req_i[w] = 1'b0;
        #2;
        checkOutput("run_gnt", gnt_o, oh);
        checkOutput("run_dout_valid", data_out_valid_o, core_data_out_valid_i ? oh : '0);
        checkOutput("run_dout", data_out_o, core_data_out_i);
        checkOutput("run_start_blocked", {core_start_enc_o, core_start_dec_o}, 2'b00);
        checkOutput("run_err", err_o, '0);
        checkOutput("run_done", done_o, '0);
        checkMux(w, 1'b1);
      end
      tick();
      start_enc_i = '0; start_dec_i = '0;
      core_done_i = 1'b0; core_data_out_valid_i = 1'b0;
      applyStimulus();
      if (lat <= TO) begin
        core_busy_i = 1'b0;
        #2;
        checkOutput("done_pulse", done_o, oh);
        checkOutput("done_auth", auth_o, auth_v ? oh : '0);
        checkOutput("done_gnt", gnt_o, oh);
        checkOutput("done_err", err_o, '0);
        checkOutput("done_dout_valid", data_out_valid_o, '0);
        checkMux(w, 1'b0);
        tick();
        #2;
        checkOutput("post_done_gnt", gnt_o, '0);
        checkOutput("post_done_done", done_o, '0);
      end else begin
        #2;
        checkOutput("abort_clr", core_clr_o, 1'b1);
        checkOutput("abort_err", err_o, oh);
        checkOutput("abort_gnt", gnt_o, '0);
        checkOutput("abort_done", done_o, '0);
        hold = $urandom_range(1, 3);
        for (int c = 0; c < hold; c++) begin
          tick();
          req_i = reqs | oh;
          #2;
          checkOutput("busy_no_regrant", gnt_o, '0);
          checkOutput("busy_clr_low", core_clr_o, 1'b0);
          checkOutput("busy_err_low", err_o, '0);
        end
        tick();
      end
    end else if (action == A_TO_GRANT) begin
      for (int c = 2; c <= TO; c++) begin
        tick();
        applyStimulus();
        #2;
        checkOutput("grant_wait_gnt", gnt_o, oh);
        checkOutput("grant_wait_err", err_o, '0);
      end
      tick();
      #2;
      checkOutput("grant_to_err", err_o, oh);
      checkOutput("grant_to_gnt", gnt_o, '0);
      checkOutput("grant_to_clr", core_clr_o, 1'b0);
    end else begin
      tick();
      start_enc_i = '0; start_dec_i = '0;
      #2;
      checkOutput("release_gnt", gnt_o, '0);
      checkOutput("release_err", err_o, (action == A_BOTH) ? oh : '0);
      checkOutput("release_done", done_o, '0);
    end
  endtask

  initial begin
    int w;
    int act, lat;
    rst_i = 1'b1;
    req_i = '1; key_valid_i = '1; data_in_valid_i = '1;
    start_enc_i = '1; start_dec_i = '1;
    key_i = '0; nonce_i = '0; data_in_i = '0;
    core_data_out_i = '0; core_data_out_valid_i = 1'b1;
    core_busy_i = 1'b0; core_done_i = 1'b0; core_auth_i = 1'b0;

    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      checkOutput("rst_gnt", gnt_o, '0);
      checkOutput("rst_done", done_o, '0);
      checkOutput("rst_err", err_o, '0);
      checkOutput("rst_auth", auth_o, '0);
      checkOutput("rst_clr", core_clr_o, 1'b0);
      checkOutput("rst_starts", {core_start_enc_o, core_start_dec_o}, 2'b00);
      checkOutput("rst_valids", {core_key_valid_o, core_data_in_valid_o}, 2'b00);
      checkOutput("rst_dout_valid", data_out_valid_o, '0);
    end
    rst_i = 1'b0;
    model_ptr = 0;

    $display("[TB] back-to-back rotation");
    for (int j = 0; j < 3; j++) runJob(2'b11, A_ENC, 12, 1'b1, 1'b0);
    $display("[TB] isolation, requester 1 alone");
    runJob(2'b10, A_DEC, 8, 1'b0, 1'b0);
    $display("[TB] start protocol error");
    runJob(2'b01, A_BOTH, 1, 1'b0, 1'b0);
    $display("[TB] request dropped in grant");
    runJob(2'b01, A_DROP, 1, 1'b0, 1'b0);
    $display("[TB] watchdog in grant and run");
    runJob(2'b11, A_TO_GRANT, 1, 1'b0, 1'b0);
    runJob(2'b11, A_ENC, TO + 1, 1'b0, 1'b0);
    $display("[TB] done on watchdog cycle, request dropped in run");
    runJob(2'b11, A_DEC, TO, 1'b1, 1'b0);
    runJob(2'b01, A_ENC, 5, 1'b1, 1'b1);
    runJob(2'b10, A_ENC, 1, 1'b0, 1'b0);

    $display("[TB] reset mid-job");
    req_i = 2'b11; start_enc_i = '0; start_dec_i = '0; core_busy_i = 1'b0;
    w = rrWinner(req_i, model_ptr);
    tick();
    start_enc_i = onehot(w);
    #2;
    checkOutput("mid_rst_grant", gnt_o, onehot(w));
    tick();
    start_enc_i = '0; core_busy_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; core_busy_i = 1'b0;
    #2;
    checkOutput("mid_rst_gnt", gnt_o, '0);
    checkOutput("mid_rst_clr", core_clr_o, 1'b0);
    checkOutput("mid_rst_err", err_o, '0);
    model_ptr = 0;

    $display("[TB] randomized jobs");
    for (int j = 0; j < 60; j++) begin
      act = $urandom_range(0, 5);
      lat = $urandom_range(1, TO);
      if (act == A_TO_RUN) begin
        act = A_ENC;
        lat = TO + 1;
      end
      runJob(N'($urandom_range(1, 3)), act, lat, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
